// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared pipeline control types
// Controller state encoding and register-select type used across the CPU.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DWAIT  = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } ctrl_state_t;

  typedef logic [4:0] regbits_t;

  localparam regbits_t REG_ZERO = 5'd0;

endpackage

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - load-use hazard compare between ID/EX load and IF/ID sources
// Purely combinational; $0 as a load destination never produces a hazard.
module load_use_detect
  import cpu_types_pkg::*;
(
  input  logic     ex_dREN,
  input  regbits_t ex_wsel,
  input  regbits_t id_rs,
  input  regbits_t id_rt,
  input  logic     id_rs_used,
  input  logic     id_rt_used,
  output logic     hazard
);

  logic rs_match;
  logic rt_match;

  assign rs_match = id_rs_used && (id_rs == ex_wsel);
  assign rt_match = id_rt_used && (id_rt == ex_wsel);
  assign hazard   = ex_dREN && (ex_wsel != REG_ZERO) && (rs_match || rt_match);

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - stall/flush sequencer for the 5-stage pipeline
// Enables/flushes are combinational on this cycle's hazards; state, watchdog and counters are flopped.
module pipeline_ctrl
  import cpu_types_pkg::*;
#(
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned DWAIT_MAX = 64
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_dREN,
  input  logic             mem_dWEN,
  input  logic             mem_halt,
  input  logic             wb_halt,
  input  logic             ex_redirect,
  input  logic             ex_dREN,
  input  logic [4:0]       ex_wsel,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_rs_used,
  input  logic             id_rt_used,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             exmem_flush,
  output logic             memwb_en,
  output logic             memwb_flush,
  output logic             halt,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  ctrl_state_t      state_q, state_d;
  logic             halt_q, halt_d;
  logic             timeout_q, timeout_d;
  logic [31:0]      dwait_cnt_q, dwait_cnt_d;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             load_use;
  logic             dstall;

  load_use_detect u_lud (
    .ex_dREN    (ex_dREN),
    .ex_wsel    (ex_wsel),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_rs_used (id_rs_used),
    .id_rt_used (id_rt_used),
    .hazard     (load_use)
  );

  assign dstall = (mem_dREN || mem_dWEN) && !dhit;

  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    state_d     = state_q;
    halt_d      = halt_q;

    if (state_q == HALTED) begin
      {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b0;
    end else if (dstall) begin
      {pc_en, ifid_en, idex_en, exmem_en} = 4'b0;
      memwb_flush = 1'b1;
      state_d     = DWAIT;
    end else begin
      if (state_q == DWAIT) state_d = RUN;
      // HALT in MEM squashes everything younger while the halt itself retires.
      if (mem_halt || state_q == DRAIN) begin
        pc_en       = 1'b0;
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
        state_d     = DRAIN;
        if (!mem_halt && wb_halt) begin
          state_d = HALTED;
          halt_d  = 1'b1;
        end
      end else if (ex_redirect) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (load_use) begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
      end else if (!ihit) begin
        pc_en      = 1'b0;
        ifid_flush = 1'b1;
      end
    end
  end

  always_comb begin
    dwait_cnt_d = '0;
    timeout_d   = timeout_q;
    cycle_cnt_d = cycle_cnt_q;
    stall_cnt_d = stall_cnt_q;
    // Count only cycles that stay in DWAIT; a zero limit disables the watchdog.
    if (state_q == DWAIT && state_d == DWAIT && DWAIT_MAX != 0) begin
      dwait_cnt_d = (dwait_cnt_q >= DWAIT_MAX) ? dwait_cnt_q : dwait_cnt_q + 32'd1;
      if (dwait_cnt_q + 32'd1 >= DWAIT_MAX) timeout_d = 1'b1;
    end
    if (state_q != HALTED) begin
      if (cycle_cnt_q != '1) cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
      if (!pc_en && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= RUN;
      halt_q      <= 1'b0;
      timeout_q   <= 1'b0;
      dwait_cnt_q <= '0;
      cycle_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      halt_q      <= halt_d;
      timeout_q   <= timeout_d;
      dwait_cnt_q <= dwait_cnt_d;
      cycle_cnt_q <= cycle_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign halt        = halt_q;
  assign mem_timeout = timeout_q;
  assign cycle_cnt   = cycle_cnt_q;
  assign stall_cnt   = stall_cnt_q;

endmodule
